// File: rtl/alu_op.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_op                                                       |
// | Description : Registered n-bit unsigned ALU, one opcode per clock, result  |
// |               plus overflow/underflow/error/zero status flags.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module alu_op #(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic [3:0]   op,
  output logic [n-1:0] out,
  output logic         of,
  output logic         un,
  output logic         err,
  output logic         zero
);

  localparam logic [3:0] c_OP_ADD = 4'b0000;
  localparam logic [3:0] c_OP_SUB = 4'b0001;
  localparam logic [3:0] c_OP_AND = 4'b0010;
  localparam logic [3:0] c_OP_OR  = 4'b0011;
  localparam logic [3:0] c_OP_XOR = 4'b0100;
  localparam logic [3:0] c_OP_NOT = 4'b0101;
  localparam logic [3:0] c_OP_SHL = 4'b0110;
  localparam logic [3:0] c_OP_MUL = 4'b0111;
  localparam logic [3:0] c_OP_SHR = 4'b1000;
  localparam logic [3:0] c_OP_DIV = 4'b1001;
  localparam logic [3:0] c_OP_MOD = 4'b1010;

  // Width n held in n+1 bits so it can be compared against a zero-extended b.
  localparam logic [n:0] c_N_WIDE = (n+1)'(n);

  logic [n:0]     w_sum;
  logic [n-1:0]   w_diff;
  logic           w_borrow;
  logic [2*n-1:0] w_prod;
  logic           w_shamt_big;
  logic [2*n-1:0] w_shl_wide;
  logic [n-1:0]   w_shl_res;
  logic           w_shl_of;
  logic [n-1:0]   w_shr_res;
  logic           w_div_zero;
  logic [n-1:0]   w_quot;
  logic [n-1:0]   w_rem;

  assign w_sum       = {1'b0, a} + {1'b0, b};
  assign w_diff      = a - b;
  assign w_borrow    = (a < b);
  assign w_prod      = {{n{1'b0}}, a} * {{n{1'b0}}, b};
  assign w_shamt_big = ({1'b0, b} >= c_N_WIDE);

  // Left shift in a double-width field: the upper half holds every bit pushed out.
  assign w_shl_wide  = {{n{1'b0}}, a} << b;
  assign w_shl_res   = w_shamt_big ? '0 : w_shl_wide[n-1:0];
  assign w_shl_of    = w_shamt_big ? (|a) : (|w_shl_wide[2*n-1:n]);
  assign w_shr_res   = w_shamt_big ? '0 : (a >> b);

  assign w_div_zero  = (b == '0);
  assign w_quot      = w_div_zero ? '0 : (a / b);
  assign w_rem       = w_div_zero ? '0 : (a % b);

  logic [n-1:0] w_out;
  logic         w_of;
  logic         w_un;
  logic         w_err;
  logic         w_zero;

  always_comb begin
    w_out = '0;
    w_of  = 1'b0;
    w_un  = 1'b0;
    w_err = 1'b0;
    case (op)
      c_OP_ADD: begin
        w_out = w_sum[n-1:0];
        w_of  = w_sum[n];
      end
      c_OP_SUB: begin
        w_out = w_diff;
        w_un  = w_borrow;
      end
      c_OP_AND: w_out = a & b;
      c_OP_OR:  w_out = a | b;
      c_OP_XOR: w_out = a ^ b;
      c_OP_NOT: w_out = ~a;
      c_OP_SHL: begin
        w_out = w_shl_res;
        w_of  = w_shl_of;
      end
      c_OP_MUL: begin
        w_out = w_prod[n-1:0];
        w_of  = |w_prod[2*n-1:n];
      end
      c_OP_SHR: w_out = w_shr_res;
      c_OP_DIV: begin
        w_out = w_quot;
        w_err = w_div_zero;
      end
      c_OP_MOD: begin
        w_out = w_rem;
        w_err = w_div_zero;
      end
      default:  w_err = 1'b1;
    endcase
  end

  // Zero comes from the value being loaded so it lines up with out.
  assign w_zero = (w_out == '0) && !w_err;

  logic [n-1:0] r_out;
  logic         r_of;
  logic         r_un;
  logic         r_err;
  logic         r_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out  <= '0;
      r_of   <= 1'b0;
      r_un   <= 1'b0;
      r_err  <= 1'b0;
      r_zero <= 1'b1;
    end else begin
      r_out  <= w_out;
      r_of   <= w_of;
      r_un   <= w_un;
      r_err  <= w_err;
      r_zero <= w_zero;
    end
  end

  assign out  = r_out;
  assign of   = r_of;
  assign un   = r_un;
  assign err  = r_err;
  assign zero = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_alu_op.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_alu_op                                                    |
// | Description : Directed self-checking bench for alu_op (n = 4).             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_alu_op;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] op;
  logic [3:0] out;
  logic       of;
  logic       un;
  logic       err;
  logic       zero;

  int total;
  int bad;

  alu_op #(.n(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .op   (op),
    .out  (out),
    .of   (of),
    .un   (un),
    .err  (err),
    .zero (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  // Observed status packed as {out, of, un, err, zero}.
  logic [7:0] obs;
  assign obs = {out, of, un, err, zero};

  task automatic apply(input logic [3:0] ta, input logic [3:0] tb_, input logic [3:0] top);
    a  = ta;
    b  = tb_;
    op = top;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    apply(4'd5, 4'd3, 4'b0000);
    total++;
    if (obs !== 8'h01) begin
      bad++;
      $display("FAIL reset_state: got %b required %b", obs, 8'h01);
    end
    apply(4'd3, 4'd4, 4'b0001);
    total++;
    if (obs !== 8'h01) begin
      bad++;
      $display("FAIL reset_hold: got %b required %b", obs, 8'h01);
    end
    rst = 1'b0;
  endtask

  task automatic test_add_sub();
    apply(4'd5, 4'd3, 4'b0000);
    total++;
    if (obs !== 8'h80) begin bad++; $display("FAIL add_5_3: got %b required %b", obs, 8'h80); end
    apply(4'd15, 4'd1, 4'b0000);
    total++;
    if (obs !== 8'h09) begin bad++; $display("FAIL add_15_1: got %b required %b", obs, 8'h09); end
    apply(4'd3, 4'd4, 4'b0001);
    total++;
    if (obs !== 8'hF4) begin bad++; $display("FAIL sub_3_4: got %b required %b", obs, 8'hF4); end
    apply(4'd4, 4'd4, 4'b0001);
    total++;
    if (obs !== 8'h01) begin bad++; $display("FAIL sub_4_4: got %b required %b", obs, 8'h01); end
  endtask

  task automatic test_mul();
    apply(4'd4, 4'd3, 4'b0111);
    total++;
    if (obs !== 8'hC0) begin bad++; $display("FAIL mul_4_3: got %b required %b", obs, 8'hC0); end
    apply(4'd8, 4'd2, 4'b0111);
    total++;
    if (obs !== 8'h09) begin bad++; $display("FAIL mul_8_2: got %b required %b", obs, 8'h09); end
  endtask

  task automatic test_logic_shift();
    apply(4'b1100, 4'b0101, 4'b0100);
    total++;
    if (obs !== 8'h90) begin bad++; $display("FAIL xor: got %b required %b", obs, 8'h90); end
    apply(4'b0101, 4'b1111, 4'b0101);
    total++;
    if (obs !== 8'hA0) begin bad++; $display("FAIL not: got %b required %b", obs, 8'hA0); end
    apply(4'b1001, 4'd1, 4'b0110);
    total++;
    if (obs !== 8'h28) begin bad++; $display("FAIL shl_of: got %b required %b", obs, 8'h28); end
    apply(4'b0001, 4'd4, 4'b0110);
    total++;
    if (obs !== 8'h09) begin bad++; $display("FAIL shl_big: got %b required %b", obs, 8'h09); end
    apply(4'b1000, 4'd3, 4'b1000);
    total++;
    if (obs !== 8'h10) begin bad++; $display("FAIL shr_3: got %b required %b", obs, 8'h10); end
    apply(4'b1111, 4'd5, 4'b1000);
    total++;
    if (obs !== 8'h01) begin bad++; $display("FAIL shr_big: got %b required %b", obs, 8'h01); end
    apply(4'd7, 4'd3, 4'b1010);
    total++;
    if (obs !== 8'h10) begin bad++; $display("FAIL mod_7_3: got %b required %b", obs, 8'h10); end
  endtask

  task automatic test_repeated_add();
    logic [3:0] acc;
    logic [3:0] cnt;
    int         iters;
    logic [2:0] zhist;
    acc   = 4'd0;
    cnt   = 4'd3;
    iters = 0;
    zhist = 3'b000;
    while (iters < 8) begin
      apply(acc, 4'd4, 4'b0000);
      acc = out;
      apply(cnt, 4'd1, 4'b0001);
      cnt = out;
      if (iters < 3) zhist[iters] = zero;
      iters++;
      if (zero === 1'b1) break;
    end
    total++;
    if (acc !== 4'd12) begin bad++; $display("FAIL rep_add_acc: got %0d required %0d", acc, 12); end
    total++;
    if (iters != 3) begin bad++; $display("FAIL rep_add_iters: got %0d required %0d", iters, 3); end
    total++;
    if (zhist !== 3'b100) begin bad++; $display("FAIL rep_add_zero_hist: got %b required %b", zhist, 3'b100); end
  endtask

  task automatic test_errors();
    apply(4'd7, 4'd0, 4'b1001);
    total++;
    if (obs !== 8'h02) begin bad++; $display("FAIL div_by_zero: got %b required %b", obs, 8'h02); end
    apply(4'd5, 4'd0, 4'b1010);
    total++;
    if (obs !== 8'h02) begin bad++; $display("FAIL mod_by_zero: got %b required %b", obs, 8'h02); end
    apply(4'd15, 4'd15, 4'b1111);
    total++;
    if (obs !== 8'h02) begin bad++; $display("FAIL invalid_op: got %b required %b", obs, 8'h02); end
    apply(4'd7, 4'd2, 4'b1001);
    total++;
    if (obs !== 8'h30) begin bad++; $display("FAIL div_7_2: got %b required %b", obs, 8'h30); end
  endtask

  task automatic test_back_to_back();
    apply(4'b1100, 4'b1010, 4'b0010);
    total++;
    if (obs !== 8'h80) begin bad++; $display("FAIL b2b_and: got %b required %b", obs, 8'h80); end
    apply(4'b1100, 4'b1010, 4'b0011);
    total++;
    if (obs !== 8'hE0) begin bad++; $display("FAIL b2b_or: got %b required %b", obs, 8'hE0); end
    apply(4'b0011, 4'd2, 4'b0110);
    total++;
    if (obs !== 8'hC0) begin bad++; $display("FAIL b2b_shl: got %b required %b", obs, 8'hC0); end
  endtask

  task automatic test_mid_cycle_and_reset();
    apply(4'd5, 4'd3, 4'b0000);
    #2;
    a  = 4'd15;
    b  = 4'd15;
    op = 4'b1111;
    #1;
    total++;
    if (obs !== 8'h80) begin bad++; $display("FAIL mid_cycle_hold: got %b required %b", obs, 8'h80); end
    rst = 1'b1;
    apply(4'd5, 4'd3, 4'b0000);
    total++;
    if (obs !== 8'h01) begin bad++; $display("FAIL mid_seq_reset: got %b required %b", obs, 8'h01); end
    rst = 1'b0;
    apply(4'd4, 4'd4, 4'b0000);
    total++;
    if (obs !== 8'h80) begin bad++; $display("FAIL after_reset_add: got %b required %b", obs, 8'h80); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    a     = '0;
    b     = '0;
    op    = '0;
    @(negedge clk);
    test_reset();
    test_add_sub();
    test_mul();
    test_logic_shift();
    test_repeated_add();
    test_errors();
    test_back_to_back();
    test_mid_cycle_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
